multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and talks to a shared instruction/data memory over a req/ack handshake. It raises traps on illegal opcodes and memory timeouts. It sits between the datapath (IR, PC, register file, ALU, branch comparator) and the unified memory port. Control-field encodings come from the shared instruction macro header (PC_SEL_*, IMM_SEL_*, ALU_SEL_*, MEM_*, LOAD_SEL_*, STORE_SEL_*, WB_SEL_*).

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay unacknowledged before a bus trap; 0 disables the timeout.
TO_W, 8, width of the wait counter; MEM_TIMEOUT must be below 2^TO_W.
INSTRET_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst  in  32  IR contents (datapath IR, loaded when ir_wr_en=1)
br_eq  in  1  comparator equal
br_lt  in  1  comparator less-than (signedness per br_un)
mem_ack  in  1  memory acknowledge; may be high in the same cycle as mem_req
trap_clr  in  1  software/debug clear of a pending trap
mem_req  out  1  memory access request
mem_rw  out  1  MEM_READ / MEM_WRITE
ir_wr_en  out  1  load IR from memory read data
pc_wr_en  out  1  update PC (PC+4 or target per PC_sel)
PC_sel  out  1  next-PC select
imm_sel  out  3  immediate format
reg_wr_en  out  1  register-file write strobe
br_un  out  1  unsigned compare
A_sel  out  1  ALU operand A select
B_sel  out  1  ALU operand B select
ALU_sel  out  4  ALU operation
load_sel  out  3  load width/sign
store_sel  out  2  store width
wb_sel  out  2  writeback source
trap  out  1  trap pending
trap_cause  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout
state  out  3  current state, for debug
instret  out  INSTRET_W  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Reset is async: state=FETCH, wait counter=0, taken flag=0, trap=0, trap_cause=0, instret=0.
- While in reset, all strobes (mem_req, ir_wr_en, pc_wr_en, reg_wr_en) are 0 and mem_rw=MEM_READ.
- FETCH: mem_req=1, mem_rw=READ, ir_wr_en=mem_ack. On ack go to DECODE.
- DECODE: one cycle, no strobes. Go to TRAP with cause 1 if opcode is not one of the 9 RV32I opcodes; otherwise go to EXEC.
- EXEC: imm_sel, A_sel, B_sel, ALU_sel and br_un are decoded from inst with the same mapping as the single-cycle decoder. For branches, taken is registered from br_eq/br_lt at the end of EXEC; JAL/JALR set taken=1, all others set taken=0. Load/store go to MEM; all others go to WB.
- MEM: mem_req=1. mem_rw=WRITE for stores only. load_sel/store_sel are decoded from funct3. On ack go to WB.
- WB: pc_wr_en=1 and PC_sel=taken ? PC_SEL_TAKEN : PC_SEL_NOTTAKEN. reg_wr_en=1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC; 0 for store and branch. Then go to FETCH.
- Datapath selects (imm/A/B/ALU/wb/load/store) hold their decoded values through EXEC, MEM and WB. They keep their defaults in FETCH, DECODE and TRAP.
- Strobes are only ever asserted in the states listed above.
- Latency with zero-wait memory (ack in the request cycle): ALU/branch/jump/LUI/AUIPC take 4 cycles; load/store take 5. Each unacked cycle adds 1.
- Wait counter: clears on state entry. It increments each FETCH/MEM cycle with mem_req=1 and mem_ack=0, saturating at all ones. When MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 with no ack, go to TRAP with cause 2 (FETCH) or 3 (MEM). If ack arrives in the same cycle as the timeout condition, the ack wins.
- TRAP: trap=1, no strobes, PC not updated, IR holds. trap_clr=1 returns to FETCH and clears trap/trap_cause the next cycle. trap_clr outside TRAP is ignored.
- Reset mid-access drops mem_req immediately (async). A memory must not complete a request after rst rises.

Optional Feature:
MC_INSTRET_EN: when defined, instret increments by 1 in every WB cycle, wraps modulo 2^INSTRET_W, and does not count trapped instructions. When undefined, the instret port still exists, is tied to 0, and no counter logic is built.

Test Plan:
- add x3,x1,x2 (0x002081B3) with ack tied high -> state sequence 0,1,2,4,0; reg_wr_en=1 only in cycle 4, ALU_sel=ALU_SEL_ADD, wb_sel=WB_SEL_ALU.
- lw (0x0000A183) with ack delayed 3 cycles in MEM -> MEM lasts 4 cycles, mem_rw=READ, load_sel=LOAD_SEL_W, 8 cycles total, reg_wr_en=1 in WB.
- beq with br_eq=1 in EXEC, then br_eq=0 in WB -> PC_sel=TAKEN in WB (registered value used); repeat with br_eq=0 -> NOTTAKEN; reg_wr_en=0 both times.
- inst=0x0000007F -> TRAP after DECODE, trap_cause=1; hold 5 cycles with no strobes; trap_clr pulse -> FETCH next cycle, trap=0.
- MEM_TIMEOUT=4, ack never asserted in FETCH -> TRAP after exactly 4 FETCH cycles, cause=2. Ack on the 4th cycle instead -> DECODE, no trap.
- With MC_INSTRET_EN: 3 retired adds plus 1 illegal -> instret=3. Assert rst mid-MEM -> mem_req=0 immediately, instret=0, state=FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP over a
// unified req/ack memory port. Define MC_INSTRET_EN to build the instret counter.
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8,
   parameter int INSTRET_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          inst,
   input  logic                 br_eq,
   input  logic                 br_lt,
   input  logic                 mem_ack,
   input  logic                 trap_clr,
   output logic                 mem_req,
   output logic                 mem_rw,
   output logic                 ir_wr_en,
   output logic                 pc_wr_en,
   output logic                 PC_sel,
   output logic [2:0]           imm_sel,
   output logic                 reg_wr_en,
   output logic                 br_un,
   output logic                 A_sel,
   output logic                 B_sel,
   output logic [3:0]           ALU_sel,
   output logic [2:0]           load_sel,
   output logic [1:0]           store_sel,
   output logic [1:0]           wb_sel,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [2:0]           state,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic       PC_SEL_NOTTAKEN = 1'b0;
   localparam logic       PC_SEL_TAKEN    = 1'b1;

   localparam logic [2:0] IMM_SEL_I = 3'd0;
   localparam logic [2:0] IMM_SEL_S = 3'd1;
   localparam logic [2:0] IMM_SEL_B = 3'd2;
   localparam logic [2:0] IMM_SEL_U = 3'd3;
   localparam logic [2:0] IMM_SEL_J = 3'd4;

   localparam logic [3:0] ALU_SEL_ADD  = 4'd0;
   localparam logic [3:0] ALU_SEL_SUB  = 4'd1;
   localparam logic [3:0] ALU_SEL_SLL  = 4'd2;
   localparam logic [3:0] ALU_SEL_SLT  = 4'd3;
   localparam logic [3:0] ALU_SEL_SLTU = 4'd4;
   localparam logic [3:0] ALU_SEL_XOR  = 4'd5;
   localparam logic [3:0] ALU_SEL_SRL  = 4'd6;
   localparam logic [3:0] ALU_SEL_SRA  = 4'd7;
   localparam logic [3:0] ALU_SEL_OR   = 4'd8;
   localparam logic [3:0] ALU_SEL_AND  = 4'd9;
   localparam logic [3:0] ALU_SEL_BSEL = 4'd10;

   localparam logic       MEM_READ  = 1'b0;
   localparam logic       MEM_WRITE = 1'b1;

   localparam logic [2:0] LOAD_SEL_B  = 3'd0;
   localparam logic [2:0] LOAD_SEL_H  = 3'd1;
   localparam logic [2:0] LOAD_SEL_W  = 3'd2;
   localparam logic [2:0] LOAD_SEL_BU = 3'd3;
   localparam logic [2:0] LOAD_SEL_HU = 3'd4;

   localparam logic [1:0] STORE_SEL_B = 2'd0;
   localparam logic [1:0] STORE_SEL_H = 2'd1;
   localparam logic [1:0] STORE_SEL_W = 2'd2;

   localparam logic [1:0] WB_SEL_MEM = 2'd0;
   localparam logic [1:0] WB_SEL_ALU = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_FETCH   = 2'd2;
   localparam logic [1:0] CAUSE_DATA    = 2'd3;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;

   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [2:0]      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            taken_q, taken_d;
   logic            trap_q, trap_d;
   logic [1:0]      cause_q, cause_d;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       f7b5;
   logic       unused_inst;

   assign opcode      = inst[6:0];
   assign f3          = inst[14:12];
   assign f7b5        = inst[30];
   assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

   logic       dec_legal;
   logic [2:0] dec_imm;
   logic       dec_a;
   logic       dec_b;
   logic [3:0] dec_alu;
   logic       dec_bun;
   logic [1:0] dec_wb;
   logic [2:0] dec_lsel;
   logic [1:0] dec_ssel;
   logic       dec_regwr;
   logic       dec_mem;
   logic       dec_store;
   logic       dec_jump;
   logic       dec_branch;
   logic       br_cond;

   logic waiting;
   logic timeout;

   logic req_s;
   logic rw_s;
   logic ir_s;
   logic pcw_s;
   logic regw_s;

   function automatic logic [3:0] alu_op(
      input logic [2:0] fn3,
      input logic       alt,
      input logic       is_r
   );
      logic [3:0] op;
      unique case (fn3)
         3'b000:  op = (is_r && alt) ? ALU_SEL_SUB : ALU_SEL_ADD;
         3'b001:  op = ALU_SEL_SLL;
         3'b010:  op = ALU_SEL_SLT;
         3'b011:  op = ALU_SEL_SLTU;
         3'b100:  op = ALU_SEL_XOR;
         3'b101:  op = alt ? ALU_SEL_SRA : ALU_SEL_SRL;
         3'b110:  op = ALU_SEL_OR;
         default: op = ALU_SEL_AND;
      endcase
      return op;
   endfunction

   function automatic logic [2:0] load_op(input logic [2:0] fn3);
      logic [2:0] op;
      unique case (fn3)
         3'b000:  op = LOAD_SEL_B;
         3'b001:  op = LOAD_SEL_H;
         3'b100:  op = LOAD_SEL_BU;
         3'b101:  op = LOAD_SEL_HU;
         default: op = LOAD_SEL_W;
      endcase
      return op;
   endfunction

   function automatic logic [1:0] store_op(input logic [2:0] fn3);
      logic [1:0] op;
      unique case (fn3[1:0])
         2'b00:   op = STORE_SEL_B;
         2'b01:   op = STORE_SEL_H;
         default: op = STORE_SEL_W;
      endcase
      return op;
   endfunction

   // Instruction decode: datapath selects and class flags from the IR
   always_comb begin
      dec_legal  = 1'b1;
      dec_imm    = IMM_SEL_I;
      dec_a      = 1'b0;
      dec_b      = 1'b0;
      dec_alu    = ALU_SEL_ADD;
      dec_bun    = 1'b0;
      dec_wb     = WB_SEL_ALU;
      dec_lsel   = LOAD_SEL_W;
      dec_ssel   = STORE_SEL_W;
      dec_regwr  = 1'b0;
      dec_mem    = 1'b0;
      dec_store  = 1'b0;
      dec_jump   = 1'b0;
      dec_branch = 1'b0;
      unique case (opcode)
         OP_R: begin
            dec_alu   = alu_op(f3, f7b5, 1'b1);
            dec_regwr = 1'b1;
         end
         OP_IMM: begin
            dec_b     = 1'b1;
            dec_alu   = alu_op(f3, f7b5, 1'b0);
            dec_regwr = 1'b1;
         end
         OP_LOAD: begin
            dec_b     = 1'b1;
            dec_wb    = WB_SEL_MEM;
            dec_lsel  = load_op(f3);
            dec_regwr = 1'b1;
            dec_mem   = 1'b1;
         end
         OP_STORE: begin
            dec_imm   = IMM_SEL_S;
            dec_b     = 1'b1;
            dec_ssel  = store_op(f3);
            dec_mem   = 1'b1;
            dec_store = 1'b1;
         end
         OP_BRANCH: begin
            dec_imm    = IMM_SEL_B;
            dec_a      = 1'b1;
            dec_b      = 1'b1;
            dec_bun    = f3[1];
            dec_branch = 1'b1;
         end
         OP_JAL: begin
            dec_imm   = IMM_SEL_J;
            dec_a     = 1'b1;
            dec_b     = 1'b1;
            dec_wb    = WB_SEL_PC4;
            dec_regwr = 1'b1;
            dec_jump  = 1'b1;
         end
         OP_JALR: begin
            dec_b     = 1'b1;
            dec_wb    = WB_SEL_PC4;
            dec_regwr = 1'b1;
            dec_jump  = 1'b1;
         end
         OP_LUI: begin
            dec_imm   = IMM_SEL_U;
            dec_b     = 1'b1;
            dec_alu   = ALU_SEL_BSEL;
            dec_regwr = 1'b1;
         end
         OP_AUIPC: begin
            dec_imm   = IMM_SEL_U;
            dec_a     = 1'b1;
            dec_b     = 1'b1;
            dec_regwr = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Branch condition from the comparator, selected by funct3
   always_comb begin
      br_cond = 1'b0;
      unique case (f3)
         3'b000:  br_cond = br_eq;
         3'b001:  br_cond = ~br_eq;
         3'b100:  br_cond = br_lt;
         3'b101:  br_cond = ~br_lt;
         3'b110:  br_cond = br_lt;
         3'b111:  br_cond = ~br_lt;
         default: br_cond = 1'b0;
      endcase
   end

   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST) && !mem_ack;

   // State and control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         taken_q <= 1'b0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         taken_q <= taken_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   // Next state, wait counter, taken flag and trap bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      taken_d = taken_q;
      trap_d  = trap_q;
      cause_d = cause_q;
      unique case (state_q)
         S_FETCH: begin
            if (mem_ack) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_FETCH;
            end
         end
         S_DECODE: begin
            if (dec_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            taken_d = dec_jump | (dec_branch & br_cond);
            state_d = dec_mem ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = S_WB;
            end else if (timeout) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_DATA;
            end
         end
         S_WB: state_d = S_FETCH;
         S_TRAP: begin
            if (trap_clr) begin
               state_d = S_FETCH;
               trap_d  = 1'b0;
               cause_d = CAUSE_NONE;
            end
         end
         default: state_d = S_FETCH;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (waiting && !mem_ack && !(&cnt_q)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   // Per-state strobes and held datapath selects
   always_comb begin
      req_s     = 1'b0;
      rw_s      = MEM_READ;
      ir_s      = 1'b0;
      pcw_s     = 1'b0;
      regw_s    = 1'b0;
      PC_sel    = PC_SEL_NOTTAKEN;
      imm_sel   = IMM_SEL_I;
      A_sel     = 1'b0;
      B_sel     = 1'b0;
      ALU_sel   = ALU_SEL_ADD;
      br_un     = 1'b0;
      wb_sel    = WB_SEL_ALU;
      load_sel  = LOAD_SEL_W;
      store_sel = STORE_SEL_W;
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         imm_sel   = dec_imm;
         A_sel     = dec_a;
         B_sel     = dec_b;
         ALU_sel   = dec_alu;
         br_un     = dec_bun;
         wb_sel    = dec_wb;
         load_sel  = dec_lsel;
         store_sel = dec_ssel;
      end
      unique case (state_q)
         S_FETCH: begin
            req_s = 1'b1;
            ir_s  = mem_ack;
         end
         S_MEM: begin
            req_s = 1'b1;
            rw_s  = dec_store ? MEM_WRITE : MEM_READ;
         end
         S_WB: begin
            pcw_s  = 1'b1;
            PC_sel = taken_q ? PC_SEL_TAKEN : PC_SEL_NOTTAKEN;
            regw_s = dec_regwr;
         end
         default: ;
      endcase
   end

   assign mem_req    = req_s & ~rst;
   assign mem_rw     = rw_s & ~rst;
   assign ir_wr_en   = ir_s & ~rst;
   assign pc_wr_en   = pcw_s & ~rst;
   assign reg_wr_en  = regw_s & ~rst;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign state      = state_q;

`ifdef MC_INSTRET_EN
   logic [INSTRET_W-1:0] instret_q, instret_d;

   // Retired count: one per WB cycle, trapped instructions never reach WB
   always_comb begin
      instret_d = instret_q;
      if (state_q == S_WB) instret_d = instret_q + INSTRET_W'(1);
   end

   // Retired-instruction counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) instret_q <= '0;
      else     instret_q <= instret_d;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: randomized instruction stream,
// instruction-level reference model, event-driven monitor.
module tb_multicycle_control_fsm;

   localparam int T = 4;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8;
   localparam logic [3:0] ALU_AND = 4'd9, ALU_BSEL = 4'd10;
   localparam logic [2:0] LD_B = 3'd0, LD_H = 3'd1, LD_W = 3'd2;
   localparam logic [2:0] LD_BU = 3'd3, LD_HU = 3'd4;
   localparam logic [1:0] ST_B = 2'd0, ST_H = 2'd1, ST_W = 2'd2;
   localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2;
   localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2;
   localparam logic [2:0] IM_U = 3'd3, IM_J = 3'd4;

   // kinds: 0 LUI 1 AUIPC 2 JAL 3 JALR 4 BR 5 LD 6 ST 7 IMM 8 R
   logic [6:0] ops    [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                              7'h03, 7'h23, 7'h13, 7'h33};
   logic [2:0] imm_t  [9] = '{IM_U, IM_U, IM_J, IM_I, IM_B,
                              IM_I, IM_S, IM_I, IM_I};
   logic       a_t    [9] = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
   logic       b_t    [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
   logic       rw_t   [9] = '{1, 1, 1, 1, 0, 1, 0, 1, 1};
   logic [1:0] wb_t   [9] = '{WB_ALU, WB_ALU, WB_PC4, WB_PC4, WB_ALU,
                              WB_MEM, WB_ALU, WB_ALU, WB_ALU};
   logic [3:0] alu_t  [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   logic [2:0] ld_t   [8] = '{LD_B, LD_H, LD_W, LD_W,
                              LD_BU, LD_HU, LD_W, LD_W};

   typedef struct {
      int         kind;
      int         cyc;
      logic [2:0] st;
      logic       rw;
      logic       irw;
      logic       pcsel;
      logic       regwr;
      logic [2:0] imm;
      logic       a;
      logic       b;
      logic       bun;
      logic [3:0] alu;
      logic [1:0] wb;
      logic [2:0] lsel;
      logic [1:0] ssel;
      logic [1:0] cause;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        br_eq, br_lt, mem_ack, trap_clr;
   logic        mem_req, mem_rw, ir_wr_en, pc_wr_en, PC_sel;
   logic [2:0]  imm_sel;
   logic        reg_wr_en, br_un, A_sel, B_sel;
   logic [3:0]  ALU_sel;
   logic [2:0]  load_sel;
   logic [1:0]  store_sel, wb_sel;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot = 0;
   int   retired = 0;
   bit   active = 0;

   multicycle_control_fsm #(
      .MEM_TIMEOUT(T), .TO_W(8), .INSTRET_W(32)
   ) dut (
      .clk(clk), .rst(rst), .inst(inst), .br_eq(br_eq), .br_lt(br_lt),
      .mem_ack(mem_ack), .trap_clr(trap_clr), .mem_req(mem_req),
      .mem_rw(mem_rw), .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en),
      .PC_sel(PC_sel), .imm_sel(imm_sel), .reg_wr_en(reg_wr_en),
      .br_un(br_un), .A_sel(A_sel), .B_sel(B_sel), .ALU_sel(ALU_sel),
      .load_sel(load_sel), .store_sel(store_sel), .wb_sel(wb_sel),
      .trap(trap), .trap_cause(trap_cause), .state(state),
      .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int kind_of(input logic [6:0] op);
      for (int i = 0; i < 9; i++) if (ops[i] == op) return i;
      return -1;
   endfunction

   // Instruction-level expectation for the WB event
   function automatic exp_t model(input logic [31:0] ins, input int k,
                                  input logic eq, input logic lt);
      exp_t e;
      logic [2:0] f3;
      logic c;
      f3 = ins[14:12];
      e.kind = 1; e.cyc = 0; e.st = 3'd4; e.rw = 1'b0; e.irw = 1'b0;
      e.cause = 2'd0;
      e.imm = imm_t[k]; e.a = a_t[k]; e.b = b_t[k];
      e.regwr = rw_t[k]; e.wb = wb_t[k];
      e.alu = (k == 0) ? ALU_BSEL : ALU_ADD;
      if (k == 7 || k == 8) begin
         e.alu = alu_t[f3];
         if (f3 == 3'd0 && k == 8 && ins[30]) e.alu = ALU_SUB;
         if (f3 == 3'd5 && ins[30]) e.alu = ALU_SRA;
      end
      e.bun = (k == 4) && f3[1];
      e.lsel = (k == 5) ? ld_t[f3] : LD_W;
      e.ssel = ST_W;
      if (k == 6 && f3[1:0] == 2'd0) e.ssel = ST_B;
      if (k == 6 && f3[1:0] == 2'd1) e.ssel = ST_H;
      c = (f3[2:1] == 2'b00) ? eq : lt;
      c = (f3[2:1] == 2'b01) ? 1'b0 : (c ^ f3[0]);
      e.pcsel = (k == 2 || k == 3) ? 1'b1 : ((k == 4) ? c : 1'b0);
      return e;
   endfunction

   task automatic cyc(input logic a, input logic e, input logic l,
                      input logic c);
      mem_ack = a; br_eq = e; br_lt = l; trap_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic push_trap(input logic [1:0] cause, input int n);
      exp_t e;
      e = model(32'h0000_0033, 8, 1'b0, 1'b0);
      e.kind = 2; e.cause = cause; e.cyc = n; e.st = 3'd5;
      q.push_back(e);
   endtask

   task automatic trap_hold(input int hold);
      repeat (hold) cyc(rb(), rb(), rb(), 1'b0);
      cyc(rb(), rb(), rb(), 1'b1);
   endtask

   task automatic do_instr(input logic [31:0] ins, input int fd,
                           input int md, input logic eq, input logic lt,
                           input logic weq, input logic wlt,
                           input int hold);
      exp_t e, m;
      int k, n;
      k = kind_of(ins[6:0]);
      e = model(ins, (k < 0) ? 8 : k, eq, lt);
      inst = ins;
      if (fd >= T) begin
         repeat (T) cyc(1'b0, rb(), rb(), rb());
         push_trap(2'd2, T + 1);
         trap_hold(hold);
         return;
      end
      m = e; m.kind = 0; m.st = 3'd0; m.rw = 1'b0; m.irw = 1'b1;
      q.push_back(m);
      repeat (fd) cyc(1'b0, rb(), rb(), rb());
      cyc(1'b1, rb(), rb(), rb());
      n = fd + 1;
      cyc(rb(), rb(), rb(), rb());
      n++;
      if (k < 0) begin
         push_trap(2'd1, n + 1);
         trap_hold(hold);
         return;
      end
      cyc(rb(), eq, lt, rb());
      n++;
      if (k == 5 || k == 6) begin
         if (md >= T) begin
            repeat (T) cyc(1'b0, rb(), rb(), rb());
            push_trap(2'd3, n + T + 1);
            trap_hold(hold);
            return;
         end
         m = e; m.kind = 0; m.st = 3'd3; m.rw = (k == 6); m.irw = 1'b0;
         q.push_back(m);
         repeat (md) cyc(1'b0, rb(), rb(), rb());
         cyc(1'b1, rb(), rb(), rb());
         n += md + 1;
      end
      e.cyc = n + 1;
      q.push_back(e);
      cyc(rb(), weq, wlt, rb());
      retired++;
   endtask

   task automatic take(input int k, output exp_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         n_tot++;
         $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
         e = q.pop_front();
         check("event_kind", k, e.kind);
         ok = (k == e.kind);
      end
   endtask

   // Monitor: pops the scoreboard on each DUT handshake, retire or trap
   initial begin : mon
      int   cnt;
      logic tprev;
      exp_t e;
      bit   ok;
      cnt = 0;
      tprev = 1'b0;
      forever begin
         @(negedge clk);
         if (!active) begin
            cnt = 0;
            tprev = 1'b0;
         end else begin
            cnt++;
            if (mem_req && mem_ack) begin
               take(0, e, ok);
               if (ok) begin
                  check("hs_state", state, e.st);
                  check("hs_mem_rw", mem_rw, e.rw);
                  check("hs_ir_wr_en", ir_wr_en, e.irw);
                  if (e.st == 3'd3) begin
                     check("hs_load_sel", load_sel, e.lsel);
                     check("hs_store_sel", store_sel, e.ssel);
                  end
               end
            end
            if (pc_wr_en) begin
               take(1, e, ok);
               if (ok) begin
                  check("wb_state", state, e.st);
                  check("wb_cycles", cnt, e.cyc);
                  check("wb_PC_sel", PC_sel, e.pcsel);
                  check("wb_reg_wr_en", reg_wr_en, e.regwr);
                  check("wb_ALU_sel", ALU_sel, e.alu);
                  check("wb_imm_sel", imm_sel, e.imm);
                  check("wb_A_sel", A_sel, e.a);
                  check("wb_B_sel", B_sel, e.b);
                  check("wb_br_un", br_un, e.bun);
                  check("wb_wb_sel", wb_sel, e.wb);
                  check("wb_load_sel", load_sel, e.lsel);
                  check("wb_store_sel", store_sel, e.ssel);
               end
               cnt = 0;
            end
            if (trap && !tprev) begin
               take(2, e, ok);
               if (ok) begin
                  check("trap_cause", trap_cause, e.cause);
                  check("trap_cycles", cnt, e.cyc);
                  check("trap_state", state, e.st);
               end
            end
            if (trap)
               check("trap_quiet", {mem_req, ir_wr_en, pc_wr_en, reg_wr_en}, 0);
            if (trap && trap_clr) cnt = 0;
            tprev = trap;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : drv
      logic [31:0] ins;
      int k;
      int exp_ir;
      rst = 1'b1; inst = 32'h0; br_eq = 0; br_lt = 0;
      mem_ack = 1'b1; trap_clr = 0;
      #23;
      check("rst_state", state, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_rw", mem_rw, 0);
      check("rst_ir_wr_en", ir_wr_en, 0);
      check("rst_pc_wr_en", pc_wr_en, 0);
      check("rst_reg_wr_en", reg_wr_en, 0);
      check("rst_trap", trap, 0);
      check("rst_trap_cause", trap_cause, 0);
      check("rst_instret", instret, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      active = 1;

      do_instr(32'h002081B3, 0, 0, 0, 0, 0, 0, 0);
      do_instr(32'h0000A183, 0, 3, 0, 0, 0, 0, 0);
      do_instr(32'h00208063, 1, 0, 1, 0, 0, 1, 0);
      do_instr(32'h00208063, 0, 0, 0, 1, 1, 0, 0);
      do_instr(32'h0000007F, 0, 0, 0, 0, 0, 0, 5);
      do_instr(32'h002081B3, 4, 0, 0, 0, 0, 0, 2);
      do_instr(32'h002081B3, 3, 0, 0, 0, 0, 0, 0);
      do_instr(32'h0020A023, 0, 4, 0, 0, 0, 0, 1);

      for (int i = 0; i < 80; i++) begin
         ins = $urandom;
         k = $urandom_range(0, 9);
         if (k < 9) begin
            ins[6:0] = ops[k];
         end else begin
            while (kind_of(ins[6:0]) >= 0) ins[6:0] = 7'($urandom);
         end
         do_instr(ins, $urandom_range(0, 5), $urandom_range(0, 5),
                  rb(), rb(), rb(), rb(), $urandom_range(0, 3));
      end

      check("queue_drained", q.size(), 0);
`ifdef MC_INSTRET_EN
      exp_ir = retired;
`else
      exp_ir = 0;
`endif
      check("instret_count", instret, exp_ir);

      active = 0;
      inst = 32'h0000A183;
      cyc(1'b1, 0, 0, 0);
      cyc(1'b0, 0, 0, 0);
      cyc(1'b0, 0, 0, 0);
      #2;
      check("mid_mem_req", mem_req, 1);
      rst = 1'b1;
      #1;
      check("rst_async_mem_req", mem_req, 0);
      check("rst_async_state", state, 0);
      check("rst_async_instret", instret, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      active = 1;
      retired = 0;
      do_instr(32'h002081B3, 0, 0, 0, 0, 0, 0, 0);
      check("post_rst_drained", q.size(), 0);
`ifdef MC_INSTRET_EN
      exp_ir = retired;
`else
      exp_ir = 0;
`endif
      check("post_rst_instret", instret, exp_ir);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
